// File: rtl/rand_scheduler_if.sv
// ---------------------------------------------------------------------------
// rand_scheduler_if
// Groups the requester-side signals of rand_scheduler into one bundle.
//
// Signals:
//   req       [3:0]  per-requester level request for one random byte
//   bound     [31:0] per-requester exclusive upper limit, requester i on
//                    bits [8i+7:8i]; 0 selects the full range 0..255
//   rand_in   [7:0]  free-running LFSR value, new every cycle
//   valid_out [3:0]  one-hot single-cycle result strobe
//   data_out  [7:0]  result byte, held until the next result
//   busy             high whenever the scheduler is not idle
//
// Modports:
//   master  the requester/LFSR side (drives req, bound, rand_in)
//   slave   the scheduler itself
// ---------------------------------------------------------------------------
interface rand_scheduler_if;
  logic [3:0]  req;
  logic [31:0] bound;
  logic [7:0]  rand_in;
  logic [3:0]  valid_out;
  logic [7:0]  data_out;
  logic        busy;

  modport master (
    output req,
    output bound,
    output rand_in,
    input  valid_out,
    input  data_out,
    input  busy
  );

  modport slave (
    input  req,
    input  bound,
    input  rand_in,
    output valid_out,
    output data_out,
    output busy
  );
endinterface

// File: rtl/rand_scheduler.sv
// ---------------------------------------------------------------------------
// rand_scheduler
// Shares one free-running random source among NREQ requesters. Each granted
// requester receives one byte uniformly reduced below its own bound using
// rejection sampling; after MAX_RETRY rejected samples the last candidate is
// folded into range by subtracting the bound, so every service finishes in a
// bounded number of cycles.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   bus          rand_scheduler_if.slave (req, bound, rand_in in;
//                valid_out, data_out, busy out)
//   o_dbg_state  current FSM state (IDLE=0, SAMPLE=1, DONE=2)
//
// Handshake: there is no ready/back-pressure. A requester holds req high at
// level until it sees its own valid_out bit, which is a one-cycle strobe;
// data_out is meaningful in that cycle and holds until the next result. The
// requester drops req in the cycle after the strobe, otherwise it simply
// re-enters arbitration behind the other requesters.
// ---------------------------------------------------------------------------
module rand_scheduler #(
  parameter int NREQ      = 4,   // fixed at 4 for this revision
  parameter int MAX_RETRY = 8
) (
  input  logic             clk,
  input  logic             rst,
  rand_scheduler_if.slave  bus,
  output logic [1:0]       o_dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int RW  = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic [IDW-1:0]   r_id;      // requester currently being served
  logic [7:0]       r_bound;   // its bound, frozen at grant
  logic [RW-1:0]    r_retry;   // rejections so far in this service
  logic [IDW-1:0]   r_last;    // most recently served requester
  logic [7:0]       r_data;    // last result

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t           w_next_state;
  logic             w_grant_any;
  logic [IDW-1:0]   w_grant_id;
  logic [7:0]       w_grant_bound;
  logic [7:0]       w_bm1;
  logic [7:0]       w_smear1;
  logic [7:0]       w_smear2;
  logic [7:0]       w_mask;
  logic [7:0]       w_cand;
  logic             w_accept;
  logic [7:0]       w_result;
  logic             w_last_try;

  // -------------------------------------------------------------------------
  // Round-robin arbitration. The search starts at r_last+1; walking the
  // offsets from farthest to nearest lets the nearest requesting index win.
  // An offset of NREQ wraps back onto r_last itself, so the previous winner
  // has the lowest priority.
  // -------------------------------------------------------------------------
  always_comb begin
    logic [IDW-1:0] idx;
    idx         = '0;
    w_grant_any = 1'b0;
    w_grant_id  = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = r_last + IDW'(k);
      if (bus.req[idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = idx;
      end
    end
  end

  assign w_grant_bound = bus.bound[{w_grant_id, 3'b000} +: 8];

  // -------------------------------------------------------------------------
  // Sampling mask: smallest 2^k-1 covering bound-1. Smearing the top set bit
  // of bound-1 downwards produces exactly that value (bound 1 -> 0,
  // bound 200 -> 255). When r_bound is 0 the mask is unused.
  // -------------------------------------------------------------------------
  assign w_bm1    = r_bound - 8'd1;
  assign w_smear1 = w_bm1    | (w_bm1    >> 1);
  assign w_smear2 = w_smear1 | (w_smear1 >> 2);
  assign w_mask   = w_smear2 | (w_smear2 >> 4);
  assign w_cand   = bus.rand_in & w_mask;

  assign w_last_try = (r_retry == RW'(MAX_RETRY - 1));

  // Accept/reject decision for the current SAMPLE cycle.
  always_comb begin
    w_accept = 1'b0;
    w_result = w_cand;
    if (r_bound == 8'd0) begin
      w_accept = 1'b1;
      w_result = bus.rand_in;
    end else if (w_cand < r_bound) begin
      w_accept = 1'b1;
      w_result = w_cand;
    end else if (w_last_try) begin
      // cand <= mask < 2*bound, so cand-bound is always below bound.
      w_accept = 1'b1;
      w_result = w_cand - r_bound;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_any) w_next_state = SAMPLE;
      SAMPLE:  if (w_accept)    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_bound <= '0;
      r_retry <= '0;
      r_last  <= IDW'(NREQ - 1);   // requester 0 gets first priority
      r_data  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_id    <= w_grant_id;
            r_bound <= w_grant_bound;
            r_retry <= '0;
          end
        end
        SAMPLE: begin
          if (w_accept) begin
            r_data <= w_result;
            r_last <= r_id;
          end else begin
            r_retry <= r_retry + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. valid_out is decoded from DONE so it can never be set in any
  // other state and is one-hot by construction.
  // -------------------------------------------------------------------------
  assign bus.valid_out = (r_state == DONE) ? (NREQ'(1) << r_id) : '0;
  assign bus.data_out  = r_data;
  assign bus.busy      = (r_state != IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rand_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rand_scheduler
// Directed and randomized stimulus for rand_scheduler. Expected results come
// from a small reference model: round-robin pick over the request vector and
// a per-sample rejection rule computed from the bound with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_rand_scheduler;
  localparam int MAX_RETRY = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rand_scheduler_if bus ();
  logic [1:0] dbg_state;

  rand_scheduler #(
    .NREQ      (4),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Bench state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  bnd [4];
  logic [7:0]  forced_q [$];   // rand_in values to use before falling back to $urandom
  logic [9:0]  exp_q [$];      // scoreboard: {requester id, data}
  int          m_last;         // model's last served requester

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_bounds();
    bus.bound = {bnd[3], bnd[2], bnd[1], bnd[0]};
  endtask

  // Round-robin reference: first requesting index after the last winner.
  function automatic int rr_pick(input logic [3:0] req_v, input int last);
    int idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = (last + k) % 4;
      if (req_v[idx]) rr_pick = idx;
    end
  endfunction

  // One sample of the rejection rule; n is the number of earlier rejections.
  function automatic void model_step(input logic [7:0] b, input logic [7:0] r, input int n,
                                     output bit acc, output logic [7:0] res);
    int mask;
    int cand;
    acc = 1'b0;
    res = 8'h00;
    if (b == 8'd0) begin
      acc = 1'b1;
      res = r;
      return;
    end
    mask = 0;
    while (mask < int'(b) - 1) mask = mask * 2 + 1;
    cand = int'(r) & mask;
    if (cand < int'(b)) begin
      acc = 1'b1;
      res = 8'(cand);
    end else if (n == MAX_RETRY - 1) begin
      acc = 1'b1;
      res = 8'(cand - int'(b));
    end
  endfunction

  function automatic logic [7:0] rand_bound();
    case ($urandom_range(0, 5))
      0:       rand_bound = 8'd0;
      1:       rand_bound = 8'd1;
      2:       rand_bound = 8'd255;
      default: rand_bound = 8'($urandom_range(2, 254));
    endcase
  endfunction

  // Drive one complete service from IDLE and check every cycle of it.
  task automatic serve(input string tag, input logic [3:0] req_v, input bit scramble);
    int         exp_id;
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] res;
    logic [9:0] e;
    bit         acc;
    exp_id      = rr_pick(req_v, m_last);
    b           = bnd[exp_id];
    bus.req     = req_v;
    set_bounds();
    bus.rand_in = 8'($urandom);
    tick();
    check({tag, "_grant_busy"},  32'(bus.busy), 32'd1);
    check({tag, "_grant_valid"}, 32'(bus.valid_out), 32'd0);
    if (scramble) begin
      bus.req   = 4'($urandom_range(0, 15));
      bus.bound = $urandom;
    end
    acc = 1'b0;
    res = 8'h00;
    for (int n = 0; n < MAX_RETRY && !acc; n++) begin
      r = (forced_q.size() > 0) ? forced_q.pop_front() : 8'($urandom);
      bus.rand_in = r;
      model_step(b, r, n, acc, res);
      tick();
      if (scramble) bus.bound = $urandom;
      if (!acc) begin
        check({tag, "_retry_busy"},  32'(bus.busy), 32'd1);
        check({tag, "_retry_valid"}, 32'(bus.valid_out), 32'd0);
      end
    end
    exp_q.push_back({2'(exp_id), res});
    e = exp_q.pop_front();
    check({tag, "_valid"},     32'(bus.valid_out), 32'(4'b0001 << e[9:8]));
    check({tag, "_data"},      32'(bus.data_out), 32'(e[7:0]));
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
    m_last = exp_id;
    tick();
    check({tag, "_post_valid"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_post_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_post_hold"},  32'(bus.data_out), 32'(e[7:0]));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_data"},  32'(bus.data_out), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence followed by randomized services
  // -------------------------------------------------------------------------
  initial begin
    logic [3:0] rv;
    rst         = 1'b1;
    bus.req     = 4'b0000;
    bus.bound   = 32'h0;
    bus.rand_in = 8'h00;
    for (int i = 0; i < 4; i++) bnd[i] = 8'd0;
    m_last = 3;
    tick();
    tick();
    reset_checks("reset");
    rst = 1'b0;

    // Single request, full range
    bnd[0] = 8'd0;
    forced_q.push_back(8'hA5);
    serve("single", 4'b0001, 1'b0);

    // Rejection: bound 10, mask 15
    bnd[1] = 8'd10;
    forced_q.push_back(8'h0E);
    forced_q.push_back(8'h3C);
    forced_q.push_back(8'h07);
    serve("reject", 4'b0010, 1'b0);

    // Fallback after MAX_RETRY rejections
    bnd[2] = 8'd5;
    for (int i = 0; i < MAX_RETRY; i++) forced_q.push_back(8'h07);
    serve("fallback", 4'b0100, 1'b0);

    // Bound 1 accepts 0 immediately; bound 255 rejects 0xFF then takes 0xFE
    bnd[3] = 8'd1;
    forced_q.push_back(8'h9C);
    serve("bound1", 4'b1000, 1'b0);
    bnd[0] = 8'd255;
    forced_q.push_back(8'hFF);
    forced_q.push_back(8'hFE);
    serve("bound255", 4'b0001, 1'b0);

    // Round-robin from reset with all requesters active
    rst = 1'b1;
    tick();
    reset_checks("rr_reset");
    rst    = 1'b0;
    m_last = 3;
    for (int i = 0; i < 4; i++) bnd[i] = 8'd1;
    for (int i = 0; i < 5; i++) serve("rr", 4'b1111, 1'b0);

    // Reset in the middle of a service
    bnd[2]      = 8'd200;
    set_bounds();
    bus.req     = 4'b0100;
    tick();
    check("midrst_grant_busy", 32'(bus.busy), 32'd1);
    bus.rand_in = 8'hFF;
    tick();
    check("midrst_sample_valid", 32'(bus.valid_out), 32'd0);
    bus.rand_in = 8'h05;
    rst = 1'b1;
    tick();
    reset_checks("midrst");
    rst    = 1'b0;
    m_last = 3;
    serve("midrst_rereq", 4'b0100, 1'b0);

    // Idle with no requests
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_busy",  32'(bus.busy), 32'd0);
      check("idle_valid", 32'(bus.valid_out), 32'd0);
    end

    // Randomized services; bound/req are disturbed during service
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 4; i++) bnd[i] = rand_bound();
      rv = 4'($urandom_range(1, 15));
      serve("rand", rv, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_scheduler.md
RAND_SCHEDULER -- requirements
Module: rand_scheduler

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 SHALL provide parameter MAX_RETRY, default 8, maximum rejection samples before fallback reduction.
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port req  input  4  per-requester level request for one random byte.
REQ-006 SHALL provide port bound  input  32  per-requester exclusive upper limit, requester i on bits [8i+7:8i]; 0 means full range 0..255.
REQ-007 SHALL provide port rand_in  input  8  free-running LFSR value, new value every cycle.
REQ-008 SHALL provide port valid_out  output  4  one-hot, single-cycle result strobe to the served requester.
REQ-009 SHALL provide port data_out  output  8  result byte, valid while the corresponding valid_out bit is high, held until the next result.
REQ-010 SHALL provide port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SAMPLE, DONE.
REQ-012 IDLE: if any req bit high, SHALL grant one requester by round-robin, starting the search at (last+1) mod 4, latch its id and bound, clear retry count, go to SAMPLE; otherwise stay in IDLE.
REQ-013 Bound and id SHALL be latched only at grant; later changes to bound or req SHALL NOT affect the service in progress.
REQ-014 SAMPLE: mask SHALL be the smallest 2^k-1 with mask >= bound-1 (bound 1 -> mask 0, bound 200 -> mask 255); cand = rand_in & mask.
REQ-015 SAMPLE: bound == 0 SHALL accept rand_in unmodified in the first SAMPLE cycle.
REQ-016 SAMPLE: cand < bound SHALL accept cand; otherwise retry count SHALL increment and the FSM SHALL stay in SAMPLE, sampling the next rand_in value.
REQ-017 SAMPLE: when a rejection occurs with retry count == MAX_RETRY-1, the FSM SHALL accept cand - bound instead of retrying (result always < bound).
REQ-018 On accept, the FSM SHALL register data_out and set valid_out[id] for exactly the following cycle (state DONE), then update last = id.
REQ-019 DONE SHALL always return to IDLE after one cycle; minimum request-to-valid latency is 2 cycles after the grant edge, maximum MAX_RETRY+1.
REQ-020 A requester deasserting req after grant SHALL still receive its valid pulse; it SHALL deassert req in the cycle after its valid pulse, or it re-enters arbitration with lowest priority.
REQ-021 No more than one valid_out bit SHALL ever be high; valid_out SHALL be 0 outside DONE.
REQ-022 Simultaneous requests SHALL be served one at a time in round-robin order; no requester SHALL wait more than 3 services.

Reset
REQ-023 When rst is high at a clock edge, the block SHALL enter IDLE with valid_out = 0, data_out = 0x00, busy = 0, retry count = 0, last = 3 (requester 0 has first priority).
REQ-024 Reset during SAMPLE or DONE SHALL abort the service with no valid pulse; requesters SHALL re-request.
REQ-025 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-026 Single request: req=0001, bound[7:0]=0, rand_in=0xA5 -> valid_out=0001 with data_out=0xA5, 2 cycles after grant.
REQ-027 Rejection: req=0010, bound=10 (mask 15), rand_in sequence 0x0E,0x3C,0x07 -> two retries, data_out=0x07, valid_out=0010.
REQ-028 Fallback: bound=5 (mask 7), rand_in held at 0x07 for all 8 samples -> data_out=0x02 after MAX_RETRY samples, valid_out asserted.
REQ-029 Round-robin: req=1111 held, bound=1 all -> grants in order 0,1,2,3,0, each data_out=0x00, one-hot valid, busy high throughout service.
REQ-030 Reset mid-service: rst pulse in SAMPLE with req=0100 -> no valid_out, all outputs at reset values next cycle, requester 2 served after rst drops.
REQ-031 Bound 1 and bound 255: bound=1 -> data_out=0x00 in first sample; bound=255, rand_in=0xFF -> rejected, next rand_in=0xFE accepted.
